noc_cmd_initiator: RTL and testbench

- Initiator/transmitter end of the 16-bit serial NoC command link.
- Accepts a parallel command (8-bit opcode + 8-bit argument) from local control logic and validates the opcode.
- Shifts the command out MSB-first as a 16-bit serial frame to the memory-side responder.
- Waits for the responder's serial acknowledgement (start bit + 8-bit status) and returns it to the requester, with a timeout.

---
 rtl/noc_cmd_initiator.sv | 160 ++++++++++++++++
 tb/tb_noc_cmd_initiator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/noc_cmd_initiator.sv
// Initiator end of the 16-bit serial NoC command link: validates a parallel
// command, shifts it out MSB-first, then collects the responder's 8-bit status.
module noc_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opcode,
  input  logic [7:0] cmd_arg,
  output logic       cmd_err,
  output logic       ser_out,
  output logic       ser_en,
  input  logic       ser_in,
  output logic       rsp_valid,
  output logic [7:0] rsp_status,
  output logic       rsp_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_ACK = 2'd2,
    RECV     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          sync0_q, sync1_q;
  logic          cmd_err_q, cmd_err_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_en_q, ser_en_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_status_q, rsp_status_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  function automatic logic opcode_legal(input logic [7:0] op);
    case (op)
      8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99: opcode_legal = 1'b1;
      default:                                  opcode_legal = 1'b0;
    endcase
  endfunction

  // Next-state and next-output decode for the command/acknowledge sequence.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    timer_d       = timer_q;
    rx_shift_d    = rx_shift_q;
    cmd_err_d     = 1'b0;
    ser_out_d     = 1'b0;
    ser_en_d      = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && opcode_legal(cmd_opcode)) begin
          state_d   = SHIFT;
          shift_d   = {cmd_opcode, cmd_arg};
          bit_cnt_d = 4'd0;
          ser_en_d  = 1'b1;
          ser_out_d = cmd_opcode[7];
        end else begin
          cmd_err_d = cmd_valid;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == 4'd15) begin
          state_d = WAIT_ACK;
          timer_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          ser_en_d  = 1'b1;
          ser_out_d = shift_q[4'd14 - bit_cnt_q];
        end
      end
      WAIT_ACK: begin
        // A start bit wins over expiry when both land in the same cycle.
        if (sync1_q) begin
          state_d  = RECV;
          rx_cnt_d = 3'd0;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_status_d  = 8'h00;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RECV: begin
        rx_shift_d = {rx_shift_q[6:0], sync1_q};
        if (rx_cnt_q == 3'd7) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_status_d  = {rx_shift_q[6:0], sync1_q};
        end else begin
          rx_cnt_d = rx_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, ser_in synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= 16'h0000;
      bit_cnt_q     <= 4'd0;
      rx_cnt_q      <= 3'd0;
      timer_q       <= '0;
      rx_shift_q    <= 8'h00;
      sync0_q       <= 1'b0;
      sync1_q       <= 1'b0;
      cmd_err_q     <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_en_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= 8'h00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      timer_q       <= timer_d;
      rx_shift_q    <= rx_shift_d;
      sync0_q       <= ser_in;
      sync1_q       <= sync0_q;
      cmd_err_q     <= cmd_err_d;
      ser_out_q     <= ser_out_d;
      ser_en_q      <= ser_en_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign cmd_err     = cmd_err_q;
  assign ser_out     = ser_out_q;
  assign ser_en      = ser_en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_noc_cmd_initiator.sv
// Bench for noc_cmd_initiator: a cycle-indexed schedule of stimulus and expected
// outputs is planned from the link's timing rules, then driven and compared.
module tb_noc_cmd_initiator;
  localparam int TO = 20;
  localparam int N  = 3000;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, ser_in = 1'b0;
  logic [7:0] cmd_opcode = 8'h00, cmd_arg = 8'h00;
  logic       cmd_ready, cmd_err, ser_out, ser_en, rsp_valid, rsp_timeout;
  logic [7:0] rsp_status;

  noc_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg), .cmd_err(cmd_err),
    .ser_out(ser_out), .ser_en(ser_en), .ser_in(ser_in),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  bit         stim_valid[N], stim_rst[N], stim_ser[N];
  logic [7:0] stim_op[N], stim_arg[N];
  bit         exp_ready[N], exp_err[N], exp_en[N], exp_out[N], exp_rv[N], exp_to[N];
  logic [7:0] exp_stv[N], exp_st[N];

  int errors = 0, checks = 0, end_c = 0;
  logic [15:0] frames[$];
  int          rsp_cycles[$];
  logic [7:0]  rsp_stats[$];
  int          to_gaps[$];
  int          first_err_cyc = -1;
  logic [7:0]  legal_ops[6] = '{8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99};

  function automatic bit is_legal(input logic [7:0] op);
    return op inside {8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99};
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Command offered in cycle h; k = WAIT_ACK cycle index where the start bit is
  // seen (k<0: responder silent). Returns r, the cycle the response is visible.
  task automatic plan_cmd(input int h, input logic [7:0] op, input logic [7:0] arg,
                          input int k, input logic [7:0] st, output int r);
    logic [15:0] fr;
    int w, c;
    stim_valid[h] = 1'b1; stim_op[h] = op; stim_arg[h] = arg;
    if (!is_legal(op)) begin
      exp_err[h+1] = 1'b1;
      r = h + 1;
    end else begin
      fr = {op, arg};
      for (int i = 0; i < 16; i++) begin
        exp_en[h+1+i] = 1'b1; exp_out[h+1+i] = fr[15-i];
      end
      w = h + 17;
      if (k >= 0) begin
        c = w + k;
        stim_ser[c-2] = 1'b1;
        for (int i = 0; i < 8; i++) stim_ser[c-1+i] = st[7-i];
      end
      if (k >= 0 && k < TO) begin
        r = w + k + 9; exp_to[r] = 1'b0; exp_stv[r] = st;
      end else begin
        r = w + TO; exp_to[r] = 1'b1; exp_stv[r] = 8'h00;
      end
      for (int i = h + 1; i < r; i++) exp_ready[i] = 1'b0;
      exp_rv[r] = 1'b1;
    end
  endtask

  task automatic abort_at(input int x, input int r);
    stim_rst[x] = 1'b1;
    for (int i = x; i <= r; i++) begin
      exp_en[i] = 1'b0; exp_out[i] = 1'b0; exp_ready[i] = 1'b1;
      exp_rv[i] = 1'b0; exp_to[i] = 1'b0;
    end
  endtask

  initial begin
    int h, r, r1, kk;
    logic [7:0] op, arg, st, cur;
    for (int i = 0; i < N; i++) begin
      stim_op[i] = 8'h00; stim_arg[i] = 8'h00; exp_ready[i] = 1'b1; exp_stv[i] = 8'h00;
    end
    stim_rst[1] = 1'b1; stim_rst[2] = 1'b1;

    // Directed: write, illegal, timeout, held-valid back-to-back, reset abort, boundaries.
    plan_cmd(4, 8'h02, 8'h5A, 3, 8'hA5, r);
    h = r; plan_cmd(h, 8'h07, 8'h11, -1, 8'h00, r);
    h = r + 2; plan_cmd(h, 8'h03, 8'hC4, -1, 8'h00, r);
    h = r + 1; plan_cmd(h, 8'h20, 8'h33, 5, 8'h3C, r1);
    for (int i = h + 1; i < r1; i++) begin
      stim_valid[i] = 1'b1; stim_op[i] = 8'h03; stim_arg[i] = 8'h10;
    end
    plan_cmd(r1, 8'h03, 8'h10, 0, 8'h81, r);
    h = r + 3; plan_cmd(h, 8'h99, 8'hA7, -1, 8'h00, r);
    abort_at(h + 9, r);
    h = h + 10; plan_cmd(h, 8'h99, 8'h00, TO - 1, 8'h5E, r);
    h = r; plan_cmd(h, 8'h52, 8'hE1, TO, 8'hFF, r);

    // Randomized traffic, with junk requests offered while busy.
    for (int t = 0; t < 30 && r < N - 90; t++) begin
      h = r + int'($urandom_range(0, 3));
      op = ($urandom_range(0, 2) != 0) ? legal_ops[$urandom_range(0, 5)] : 8'($urandom);
      arg = 8'($urandom); st = 8'($urandom);
      kk = int'($urandom_range(0, TO + 1));
      if ($urandom_range(0, 7) == 0) kk = -1;
      plan_cmd(h, op, arg, kk, st, r);
      for (int i = h + 1; i < r; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          stim_valid[i] = 1'b1; stim_op[i] = 8'($urandom); stim_arg[i] = 8'($urandom);
        end
      end
    end
    end_c = r + 6;

    cur = 8'h00;
    for (int i = 1; i < N; i++) begin
      if (stim_rst[i]) cur = 8'h00;
      else if (exp_rv[i]) cur = exp_stv[i];
      exp_st[i] = cur;
    end

    fork
      begin
        for (int c = 1; c < end_c; c++) begin
          @(posedge clk); #1;
          rst = stim_rst[c]; cmd_valid = stim_valid[c]; cmd_opcode = stim_op[c];
          cmd_arg = stim_arg[c]; ser_in = stim_ser[c];
        end
      end
      begin
        logic [15:0] fr;
        int nb, last_en;
        fr = 16'h0000; nb = 0; last_en = 0;
        for (int c = 1; c < end_c; c++) begin
          @(negedge clk);
          chk("cmd_ready", c, 32'(cmd_ready), 32'(exp_ready[c]));
          chk("cmd_err", c, 32'(cmd_err), 32'(exp_err[c]));
          chk("ser_en", c, 32'(ser_en), 32'(exp_en[c]));
          chk("ser_out", c, 32'(ser_out), 32'(exp_out[c]));
          chk("rsp_valid", c, 32'(rsp_valid), 32'(exp_rv[c]));
          chk("rsp_status", c, 32'(rsp_status), 32'(exp_st[c]));
          if (exp_rv[c]) chk("rsp_timeout", c, 32'(rsp_timeout), 32'(exp_to[c]));
          if (cmd_err === 1'b1 && first_err_cyc < 0) first_err_cyc = c;
          if (ser_en === 1'b1) begin
            fr = {fr[14:0], ser_out}; nb++; last_en = c;
            if (nb == 16) frames.push_back(fr);
          end else begin
            nb = 0;
          end
          if (rsp_valid === 1'b1) begin
            rsp_cycles.push_back(c); rsp_stats.push_back(rsp_status);
            if (rsp_timeout === 1'b1) to_gaps.push_back(c - last_en - 1);
          end
        end
      end
    join

    // Hand-computed anchors for the directed part of the schedule.
    chk("frame_count_min", 0, 32'(frames.size() >= 5), 32'd1);
    chk("rsp_count_min", 0, 32'(rsp_cycles.size() >= 3 && to_gaps.size() >= 1), 32'd1);
    if (frames.size() >= 5 && rsp_cycles.size() >= 3 && to_gaps.size() >= 1) begin
      chk("frame0_write", 0, 32'(frames[0]), 32'h025A);
      chk("frame3_queued", 0, 32'(frames[3]), 32'h0310);
      chk("frame4_after_rst", 0, 32'(frames[4]), 32'h9900);
      chk("rsp0_cycle", 0, 32'(rsp_cycles[0]), 32'd33);
      chk("rsp0_status", 0, 32'(rsp_stats[0]), 32'hA5);
      chk("timeout_wait_cycles", 0, 32'(to_gaps[0]), 32'd20);
    end
    chk("illegal_err_cycle", 0, 32'(first_err_cyc), 32'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
